// File: rtl/car_lane.sv
// car_lane: one lane of moving cars for the LED-matrix game.
// On each enable tick the lane shifts one cell away from the entry. A spawn
// FSM decides what enters the entry cell. It emits CAR_LEN occupied cells
// for an accepted trigger, then forces MIN_GAP empty cells. hit is a
// registered flag: the player cell overlaps a car.
module car_lane #(
    parameter int LANE_LEN = 16,
    parameter int CAR_LEN  = 2,
    parameter int MIN_GAP  = 2,
    parameter int DIR      = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        trigger,
    input  logic                        clear,
    input  logic [$clog2(LANE_LEN)-1:0] player_pos,
    input  logic                        player_valid,
    output logic [LANE_LEN-1:0]         lane,
    output logic                        spawn_ack,
    output logic                        spawn_drop,
    output logic                        car_exit,
    output logic                        hit
);

    localparam int PW = $clog2(LANE_LEN);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] body, body_nxt;
    logic [CW-1:0] gap, gap_nxt;
    logic          ins;
    logic          ack_nxt;
    logic          drop_nxt;
    logic [LANE_LEN-1:0] shifted;
    logic          far_cell;
    logic          hit_nxt;

    // Spawn FSM: the entry-cell value and the next state for a tick.
    // These values are committed only when enable is high.
    always_comb begin
        state_nxt = state;
        body_nxt  = body;
        gap_nxt   = gap;
        ins       = 1'b0;
        ack_nxt   = 1'b0;
        drop_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    ins     = 1'b1;
                    ack_nxt = 1'b1;
                    if (CAR_LEN > 1) begin
                        state_nxt = EMIT;
                        body_nxt  = CW'(CAR_LEN - 1);
                    end else if (MIN_GAP > 0) begin
                        state_nxt = GAP;
                        gap_nxt   = CW'(MIN_GAP);
                    end
                end
            end
            EMIT: begin
                ins      = 1'b1;
                drop_nxt = trigger;
                body_nxt = body - CW'(1);
                if (body == CW'(1)) begin
                    if (MIN_GAP > 0) begin
                        state_nxt = GAP;
                        gap_nxt   = CW'(MIN_GAP);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                drop_nxt = trigger;
                gap_nxt  = gap - CW'(1);
                if (gap == CW'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lane shift toward the far end. far_cell is the cell about to leave the lane.
    always_comb begin
        if (DIR == 0) begin
            shifted  = {lane[LANE_LEN-2:0], ins};
            far_cell = lane[LANE_LEN-1];
        end else begin
            shifted  = {ins, lane[LANE_LEN-1:1]};
            far_cell = lane[0];
        end
    end

    // Collision lookup against the registered lane. A position beyond the lane never hits.
    always_comb begin
        hit_nxt = 1'b0;
        for (int i = 0; i < LANE_LEN; i++) begin
            if (player_valid && (int'(player_pos) == i)) hit_nxt = lane[i];
        end
    end

    // Lane, FSM and pulse registers: priority is reset, then clear, then tick, then hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane       <= '0;
            state      <= IDLE;
            body       <= '0;
            gap        <= '0;
            spawn_ack  <= 1'b0;
            spawn_drop <= 1'b0;
            car_exit   <= 1'b0;
        end else if (clear) begin
            lane       <= '0;
            state      <= IDLE;
            body       <= '0;
            gap        <= '0;
            spawn_ack  <= 1'b0;
            spawn_drop <= 1'b0;
            car_exit   <= 1'b0;
        end else if (enable) begin
            lane       <= shifted;
            state      <= state_nxt;
            body       <= body_nxt;
            gap        <= gap_nxt;
            spawn_ack  <= ack_nxt;
            spawn_drop <= drop_nxt;
            car_exit   <= far_cell;
        end else begin
            spawn_ack  <= 1'b0;
            spawn_drop <= 1'b0;
            car_exit   <= 1'b0;
        end
    end

    // Collision flag, refreshed every clock from the current lane.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hit <= 1'b0;
        else          hit <= hit_nxt;
    end

endmodule
